// File: rtl/debounce_sync.sv
// Synchronizes and debounces one asynchronous input into the clk domain.
// Presents a clean level, one-cycle edge pulses and a busy flag.
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   sync_q;
  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   differ;
  logic                   accept;

  assign sync_q = chain_q[SYNC_STAGES-1];

  always_comb begin
    differ  = (sync_q != stable_q);
    accept  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (differ) begin
          if (DEBOUNCE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (!differ) begin
          // a bounce back to the current level restarts the run
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    stable_d = accept ? sync_q : stable_q;
    rise_d   = accept & sync_q;
    fall_d   = accept & ~sync_q;
    busy_d   = (state_d == COUNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q  <= IDLE;
      cnt_q    <= '0;
      stable_q <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      chain_q  <= {chain_q[SYNC_STAGES-2:0], raw_i};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized bench for debounce_sync against a sample-history model.
// Directed scenarios cover latency, glitch rejection and async reset.
module tb_debounce_sync;

  localparam int   SS = 2;
  localparam int   DC = 16;
  localparam logic RL = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_i = 1'b0;
  logic stable_o, rise_o, fall_o, busy_o;

  debounce_sync #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (RL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (raw_i),
    .stable_o(stable_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // raw samples taken at recent edges; front is what the debouncer sees
  logic hist[$];
  logic m_stable, m_rise, m_fall;
  int   run;

  int edge_no, first_rise, first_fall, n_rise, n_fall, n_busy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(RL);
    m_stable = RL;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    run      = 0;
  endfunction

  // A change is accepted after DC consecutive synchronized samples
  // that differ from the current level.
  function automatic void model_edge(input logic r);
    logic s;
    s = hist.pop_front();
    hist.push_back(r);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_stable) begin
      run++;
      if (run == DC) begin
        m_stable = s;
        m_rise   = s;
        m_fall   = ~s;
        run      = 0;
      end
    end else begin
      run = 0;
    end
  endfunction

  function automatic void clr_stats();
    edge_no    = 0;
    first_rise = -1;
    first_fall = -1;
    n_rise     = 0;
    n_fall     = 0;
    n_busy     = 0;
  endfunction

  task automatic step(input logic r);
    int cur;
    @(negedge clk);
    raw_i = r;
    @(posedge clk);
    model_edge(r);
    #1;
    cur = edge_no;
    edge_no++;
    chk("stable", stable_o, m_stable);
    chk("rise", rise_o, m_rise);
    chk("fall", fall_o, m_fall);
    chk("busy", busy_o, (run > 0));
    chk("excl", rise_o & fall_o, 0);
    if (rise_o) begin
      n_rise++;
      if (first_rise < 0) first_rise = cur;
    end
    if (fall_o) begin
      n_fall++;
      if (first_fall < 0) first_fall = cur;
    end
    if (busy_o) n_busy++;
  endtask

  // called between a rising edge and the following falling edge
  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_stable", stable_o, RL);
    chk("rst_rise", rise_o, 0);
    chk("rst_fall", fall_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // raw high through reset, then held
    raw_i = 1'b1;
    do_reset();
    clr_stats();
    repeat (25) step(1'b1);
    chk("t1_lat", first_rise, 17);
    chk("t1_nrise", n_rise, 1);
    chk("t1_nfall", n_fall, 0);

    // falling change from stable 1
    clr_stats();
    repeat (25) step(1'b0);
    chk("t5_lat", first_fall, 17);
    chk("t5_nrise", n_rise, 0);
    chk("t5_nfall", n_fall, 1);

    // 15-cycle pulse is rejected
    clr_stats();
    repeat (15) step(1'b1);
    repeat (20) step(1'b0);
    chk("t3_stable", stable_o, 0);
    chk("t3_busy", busy_o, 0);
    chk("t3_pulses", n_rise + n_fall, 0);

    // clean rise from idle 0, busy window
    clr_stats();
    repeat (25) step(1'b1);
    chk("t2_lat", first_rise, 17);
    chk("t2_busy_cyc", n_busy, 15);
    chk("t2_nfall", n_fall, 0);

    // chatter for 30 cycles, then hold high
    do_reset();
    clr_stats();
    for (int i = 0; i < 30; i++) step(((i / 3) % 2) == 0);
    repeat (25) step(1'b1);
    chk("t4_nrise", n_rise, 1);
    chk("t4_lat", first_rise, 47);

    // reset in the middle of a count
    do_reset();
    clr_stats();
    repeat (12) step(1'b1);
    chk("t6_busy_pre", busy_o, 1);
    chk("t6_stable_pre", stable_o, 0);
    do_reset();
    clr_stats();
    repeat (25) step(1'b1);
    chk("t6_lat", first_rise, 17);

    // random levels and hold lengths
    for (int seg = 0; seg < 60; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      repeat (len) step(lvl);
      if ($urandom_range(0, 15) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
